// File: rtl/jtag_pkg.sv
// jtag_pkg
// Shared definitions for the JTAG instruction/data register block.
// Holds the TAP state encoding (the same encoding the upstream TAP
// controller drives onto its state output) and the 4-bit opcode constants.
// Opcodes are zero-extended by the consumer when the IR is wider than 4 bits.
// The all-ones BYPASS opcode is width dependent, so it is built locally as '1.

package jtag_pkg;

   // IEEE 1149.1 style TAP state encoding, all sixteen codes used
   typedef enum logic [3:0] {
      TAP_EXIT2_DR         = 4'h0,
      TAP_EXIT1_DR         = 4'h1,
      TAP_SHIFT_DR         = 4'h2,
      TAP_PAUSE_DR         = 4'h3,
      TAP_SELECT_IR        = 4'h4,
      TAP_UPDATE_DR        = 4'h5,
      TAP_CAPTURE_DR       = 4'h6,
      TAP_SELECT_DR        = 4'h7,
      TAP_EXIT2_IR         = 4'h8,
      TAP_EXIT1_IR         = 4'h9,
      TAP_SHIFT_IR         = 4'hA,
      TAP_PAUSE_IR         = 4'hB,
      TAP_RUN_IDLE         = 4'hC,
      TAP_UPDATE_IR        = 4'hD,
      TAP_CAPTURE_IR       = 4'hE,
      TAP_TEST_LOGIC_RESET = 4'hF
   } tapState_t;

   localparam logic [3:0] OPC_IDCODE = 4'b0001;
   localparam logic [3:0] OPC_USER   = 4'b1000;

   // Value loaded into the IR shift register on Capture-IR (LSBs 01)
   localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_shift_reg.sv
// jtag_shift_reg
// Generic JTAG shift register: parallel capture, right shift with TDI
// entering at the MSB, otherwise hold. Used for the IR, IDCODE and USER
// registers.
// Ports:
//   clk_i        - TCK
//   rst_i        - synchronous active-high reset, clears the register
//   capture_i    - load captureVal_i (has priority over shift_i)
//   shift_i      - shift right one place, tdi_i into the MSB
//   captureVal_i - parallel capture value
//   tdi_i        - serial data in
//   data_o       - current register contents
//   lsb_o        - current LSB, i.e. the bit that leaves on the next shift

import jtag_pkg::*;

module jtag_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             capture_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] captureVal_i,
   input  logic             tdi_i,
   output logic [WIDTH-1:0] data_o,
   output logic             lsb_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] shifted;

   // A one-bit register simply becomes TDI; wider ones drop their LSB
   generate
      if (WIDTH == 1) begin : gSingle
         assign shifted = tdi_i;
      end else begin : gMulti
         assign shifted = {tdi_i, data_q[WIDTH-1:1]};
      end
   endgenerate

   // Capture wins over shift; with neither strobe the register holds,
   // which covers Pause/Exit and every state not aimed at this register
   always_comb begin
      data_d = data_q;
      if (capture_i) begin
         data_d = captureVal_i;
      end else if (shift_i) begin
         data_d = shifted;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;
   assign lsb_o  = data_q[0];

endmodule

// File: rtl/jtag_ir_dr.sv
// jtag_ir_dr
// JTAG instruction register plus BYPASS / IDCODE / USER data registers,
// driven by the TAP state published by an external TAP controller.
// Optional feature macro: JTAG_IDCODE_EN. When defined, the 32-bit IDCODE
// register exists and IDCODE is the reset instruction. When undefined, no
// IDCODE register is built, the IDCODE opcode decodes as BYPASS and the
// reset instruction is BYPASS.
// Ports:
//   tck_i      - sole clock, all state changes on the rising edge
//   trst_i     - synchronous active-high reset, overrides state_i
//   state_i    - current TAP state (jtag_pkg::tapState_t)
//   tdi_i      - serial data in
//   tdo_o      - registered serial data out
//   tdo_en_o   - high while tdo_o carries shift data
//   user_in_i  - parallel value captured into the USER register
//   user_out_o - parallel value latched from the USER register on Update-DR
//   user_upd_o - one-cycle pulse when user_out_o is written
//   ir_out_o   - currently active instruction

import jtag_pkg::*;

module jtag_ir_dr #(
   parameter int          IR_WIDTH     = 4,
   parameter int          USER_WIDTH   = 8,
   parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
) (
   input  logic                  tck_i,
   input  logic                  trst_i,
   input  tapState_t             state_i,
   input  logic                  tdi_i,
   output logic                  tdo_o,
   output logic                  tdo_en_o,
   input  logic [USER_WIDTH-1:0] user_in_i,
   output logic [USER_WIDTH-1:0] user_out_o,
   output logic                  user_upd_o,
   output logic [IR_WIDTH-1:0]   ir_out_o
);

   localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
   localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
   localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(OPC_USER);
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);
`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
`endif

   logic [IR_WIDTH-1:0]   irOut_q;
   logic [USER_WIDTH-1:0] userOut_q;
   logic                  userUpd_q;
   logic                  bypass_q;
   logic                  tdo_q;
   logic                  tdoEn_q;
   logic                  tdo_d;
   logic                  tdoEn_d;

   logic captureIr;
   logic shiftIr;
   logic updateIr;
   logic captureDr;
   logic shiftDr;
   logic updateDr;
   logic testLogicReset;

   logic selIdcode;
   logic selUser;
   logic selBypass;

   logic [IR_WIDTH-1:0]   irData;
   logic                  irLsb;
   logic [USER_WIDTH-1:0] userData;
   logic                  userLsb;
   logic                  idcodeLsb;

   // Decode the TAP state into one-hot strobes. Any encoding that matches
   // none of them leaves every register holding its value.
   always_comb begin
      captureIr      = (state_i == TAP_CAPTURE_IR);
      shiftIr        = (state_i == TAP_SHIFT_IR);
      updateIr       = (state_i == TAP_UPDATE_IR);
      captureDr      = (state_i == TAP_CAPTURE_DR);
      shiftDr        = (state_i == TAP_SHIFT_DR);
      updateDr       = (state_i == TAP_UPDATE_DR);
      testLogicReset = (state_i == TAP_TEST_LOGIC_RESET);
   end

   // Instruction decode: anything that is not a recognised opcode selects
   // the bypass bit. IR_OUT only moves on Update-IR / Test-Logic-Reset, so
   // the selection is stable for the whole of a DR scan.
   always_comb begin
      selIdcode = 1'b0;
`ifdef JTAG_IDCODE_EN
      selIdcode = (irOut_q == IR_IDCODE);
`endif
      selUser   = (irOut_q == IR_USER);
      selBypass = !selIdcode && !selUser;
   end

   jtag_shift_reg #(
      .WIDTH(IR_WIDTH)
   ) uIrShift (
      .clk_i        (tck_i),
      .rst_i        (trst_i),
      .capture_i    (captureIr),
      .shift_i      (shiftIr),
      .captureVal_i (IR_CAPTURE),
      .tdi_i        (tdi_i),
      .data_o       (irData),
      .lsb_o        (irLsb)
   );

   jtag_shift_reg #(
      .WIDTH(USER_WIDTH)
   ) uUserShift (
      .clk_i        (tck_i),
      .rst_i        (trst_i),
      .capture_i    (captureDr && selUser),
      .shift_i      (shiftDr && selUser),
      .captureVal_i (user_in_i),
      .tdi_i        (tdi_i),
      .data_o       (userData),
      .lsb_o        (userLsb)
   );

`ifdef JTAG_IDCODE_EN
   logic [31:0] idcodeData;

   jtag_shift_reg #(
      .WIDTH(32)
   ) uIdcodeShift (
      .clk_i        (tck_i),
      .rst_i        (trst_i),
      .capture_i    (captureDr && selIdcode),
      .shift_i      (shiftDr && selIdcode),
      .captureVal_i (IDCODE_VALUE),
      .tdi_i        (tdi_i),
      .data_o       (idcodeData),
      .lsb_o        (idcodeLsb)
   );
`else
   assign idcodeLsb = 1'b0;
`endif

   // TDO source for the next edge: the LSB of whichever register is being
   // shifted on that same edge, so TDO trails state entry by one cycle.
   // Outside the shift states TDO is forced low with the enable dropped.
   always_comb begin
      tdo_d   = 1'b0;
      tdoEn_d = 1'b0;
      if (shiftIr) begin
         tdo_d   = irLsb;
         tdoEn_d = 1'b1;
      end else if (shiftDr) begin
         tdoEn_d = 1'b1;
         if (selUser) begin
            tdo_d = userLsb;
         end else if (selIdcode) begin
            tdo_d = idcodeLsb;
         end else begin
            tdo_d = bypass_q;
         end
      end
   end

   // Output and control registers. Reset has priority over any state so a
   // scan interrupted mid-shift restarts cleanly from the next capture.
   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         irOut_q   <= IR_RESET;
         userOut_q <= '0;
         userUpd_q <= 1'b0;
         bypass_q  <= 1'b0;
         tdo_q     <= 1'b0;
         tdoEn_q   <= 1'b0;
      end else begin
         tdo_q     <= tdo_d;
         tdoEn_q   <= tdoEn_d;
         userUpd_q <= updateDr && selUser;
         if (updateDr && selUser) begin
            userOut_q <= userData;
         end
         if (testLogicReset) begin
            irOut_q <= IR_RESET;
         end else if (updateIr) begin
            irOut_q <= irData;
         end
         if (captureDr && selBypass) begin
            bypass_q <= 1'b0;
         end else if (shiftDr && selBypass) begin
            bypass_q <= tdi_i;
         end
      end
   end

   assign tdo_o      = tdo_q;
   assign tdo_en_o   = tdoEn_q;
   assign user_out_o = userOut_q;
   assign user_upd_o = userUpd_q;
   assign ir_out_o   = irOut_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// tb_jtag_ir_dr
// Directed bench for jtag_ir_dr. Expected TDO bits are queued as each shift
// step is driven and popped once the DUT has clocked that step.
// Expectations follow JTAG_IDCODE_EN the same way the design does.

import jtag_pkg::*;

module tb_jtag_ir_dr;

   localparam logic [31:0] IDCODE = 32'h1234_5001;
`ifdef JTAG_IDCODE_EN
   localparam logic [3:0]  RESET_IR   = 4'b0001;
   localparam logic [31:0] RESET_SCAN = IDCODE;
`else
   localparam logic [3:0]  RESET_IR   = 4'b1111;
   localparam logic [31:0] RESET_SCAN = 32'h0;
`endif

   logic       clk = 1'b0;
   logic       trst;
   tapState_t  state;
   logic       tdi;
   logic [7:0] userIn;
   logic       tdo;
   logic       tdoEn;
   logic [7:0] userOut;
   logic       userUpd;
   logic [3:0] irOut;

   logic expQ[$];
   int   assertCount = 0;
   int   failCount   = 0;

   always #5 clk = ~clk;

   jtag_ir_dr #(
      .IR_WIDTH     (4),
      .USER_WIDTH   (8),
      .IDCODE_VALUE (IDCODE)
   ) dut (
      .tck_i      (clk),
      .trst_i     (trst),
      .state_i    (state),
      .tdi_i      (tdi),
      .tdo_o      (tdo),
      .tdo_en_o   (tdoEn),
      .user_in_i  (userIn),
      .user_out_o (userOut),
      .user_upd_o (userUpd),
      .ir_out_o   (irOut)
   );

   // One comparison: counts it, and on mismatch counts and reports it
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one TAP state and TDI bit at the falling edge, return just after
   // the rising edge that consumes them
   task automatic applyStimulus(input tapState_t st, input logic bitIn);
      @(negedge clk);
      state = st;
      tdi   = bitIn;
      @(posedge clk);
      #1;
   endtask

   // n shift steps in state st; tdiVec/expVec are LSB-first bit streams
   task automatic shiftSeq(input tapState_t st, input int n, input logic [31:0] tdiVec,
                           input logic [31:0] expVec, input string tag);
      logic expBit;
      for (int i = 0; i < n; i++) begin
         expQ.push_back(expVec[i]);
         applyStimulus(st, tdiVec[i]);
         expBit = expQ.pop_front();
         checkOutput($sformatf("%s_tdo%0d", tag, i), 32'(tdo), 32'(expBit));
         checkOutput($sformatf("%s_en%0d", tag, i), 32'(tdoEn), 32'd1);
      end
   endtask

   // Full IR scan from Run-Test/Idle; also checks the captured 01 pattern
   task automatic loadIr(input logic [3:0] val);
      applyStimulus(TAP_SELECT_DR, 1'b0);
      applyStimulus(TAP_SELECT_IR, 1'b0);
      applyStimulus(TAP_CAPTURE_IR, 1'b0);
      shiftSeq(TAP_SHIFT_IR, 4, 32'(val), 32'h1, "ir_capture");
      applyStimulus(TAP_EXIT1_IR, 1'b0);
      checkOutput("ir_exit_en", 32'(tdoEn), 32'd0);
      applyStimulus(TAP_UPDATE_IR, 1'b0);
      checkOutput("ir_out", 32'(irOut), 32'(val));
      applyStimulus(TAP_RUN_IDLE, 1'b0);
   endtask

   // Enter Shift-DR via Capture-DR and shift n bits
   task automatic scanDr(input int n, input logic [31:0] tdiVec,
                         input logic [31:0] expVec, input string tag);
      applyStimulus(TAP_SELECT_DR, 1'b0);
      applyStimulus(TAP_CAPTURE_DR, 1'b0);
      shiftSeq(TAP_SHIFT_DR, n, tdiVec, expVec, tag);
   endtask

   // Leave Shift-DR through Update-DR back to Run-Test/Idle
   task automatic finishDr(input string tag, input logic expUpd, input logic [7:0] expUserOut);
      applyStimulus(TAP_EXIT1_DR, 1'b0);
      checkOutput({tag, "_exit_en"}, 32'(tdoEn), 32'd0);
      applyStimulus(TAP_UPDATE_DR, 1'b0);
      checkOutput({tag, "_upd"}, 32'(userUpd), 32'(expUpd));
      checkOutput({tag, "_userout"}, 32'(userOut), 32'(expUserOut));
      applyStimulus(TAP_RUN_IDLE, 1'b0);
      checkOutput({tag, "_upd_clear"}, 32'(userUpd), 32'd0);
      checkOutput({tag, "_userout_hold"}, 32'(userOut), 32'(expUserOut));
   endtask

   initial begin
      trst   = 1'b1;
      state  = TAP_RUN_IDLE;
      tdi    = 1'b0;
      userIn = 8'h00;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ir_out", 32'(irOut), 32'(RESET_IR));
      checkOutput("rst_tdo", 32'(tdo), 32'd0);
      checkOutput("rst_tdo_en", 32'(tdoEn), 32'd0);
      checkOutput("rst_user_out", 32'(userOut), 32'd0);
      checkOutput("rst_user_upd", 32'(userUpd), 32'd0);
      @(negedge clk);
      trst = 1'b0;

      // DR scan with the reset instruction: IDCODE LSB first, or bypass zeros
      scanDr(32, 32'h0, RESET_SCAN, "reset_dr");
      finishDr("reset_dr", 1'b0, 8'h00);

      // BYPASS: TDI 1,0,1,1 appears one bit late as 0,1,0,1
      loadIr(4'b1111);
      scanDr(4, 32'b1101, 32'b1010, "bypass");
      finishDr("bypass", 1'b0, 8'h00);

      // Unassigned opcode behaves as bypass
      loadIr(4'b0101);
      scanDr(3, 32'b011, 32'b110, "unknown_op");
      finishDr("unknown_op", 1'b0, 8'h00);

      // USER: capture A5, shift in 3C with a 5-cycle Pause-DR in the middle
      userIn = 8'hA5;
      loadIr(4'b1000);
      scanDr(4, 32'hC, 32'h5, "user_lo");
      applyStimulus(TAP_EXIT1_DR, 1'b0);
      checkOutput("user_exit1_en", 32'(tdoEn), 32'd0);
      for (int p = 0; p < 5; p++) begin
         applyStimulus(TAP_PAUSE_DR, 1'b1);
         checkOutput($sformatf("pause_en%0d", p), 32'(tdoEn), 32'd0);
         checkOutput($sformatf("pause_tdo%0d", p), 32'(tdo), 32'd0);
      end
      applyStimulus(TAP_EXIT2_DR, 1'b1);
      shiftSeq(TAP_SHIFT_DR, 4, 32'h3, 32'hA, "user_hi");
      userIn = 8'h00;
      finishDr("user", 1'b1, 8'h3C);

      // IDCODE opcode: IDCODE bits when enabled, bypass otherwise
      loadIr(4'b0001);
      scanDr(16, 32'h0, 32'(RESET_SCAN[15:0]), "idcode_op");
      finishDr("idcode_op", 1'b0, 8'h3C);

      // TRST at USER shift bit 3 overrides Shift-DR
      userIn = 8'h5A;
      loadIr(4'b1000);
      scanDr(3, 32'h0, 32'b010, "user_pre");
      @(negedge clk);
      trst  = 1'b1;
      state = TAP_SHIFT_DR;
      @(posedge clk);
      #1;
      checkOutput("trst_ir_out", 32'(irOut), 32'(RESET_IR));
      checkOutput("trst_tdo", 32'(tdo), 32'd0);
      checkOutput("trst_tdo_en", 32'(tdoEn), 32'd0);
      checkOutput("trst_user_out", 32'(userOut), 32'd0);
      checkOutput("trst_user_upd", 32'(userUpd), 32'd0);
      @(negedge clk);
      trst  = 1'b0;
      state = TAP_RUN_IDLE;
      scanDr(8, 32'h0, 32'(RESET_SCAN[7:0]), "restart");
      finishDr("restart", 1'b0, 8'h00);

      // Test-Logic-Reset reloads the reset instruction without TRST
      loadIr(4'b1000);
      applyStimulus(TAP_TEST_LOGIC_RESET, 1'b0);
      checkOutput("tlr_ir_out", 32'(irOut), 32'(RESET_IR));
      applyStimulus(TAP_RUN_IDLE, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/jtag_ir_dr.md
JTAG_IR_DR -- requirements
Module: jtag_ir_dr

Interface
REQ-001 Parameter IR_WIDTH, default 4, instruction register length in bits (min 2).
REQ-002 Parameter USER_WIDTH, default 8, user data register length in bits.
REQ-003 Parameter IDCODE_VALUE, default 32'h1234_5001, 32-bit device ID (bit 0 SHALL be 1).
REQ-004 TCK  input  1  sole clock; all state changes on rising edge.
REQ-005 TRST  input  1  reset, synchronous, active-high.
REQ-006 STATE  input  4  current TAP state from upstream tar_controller, package encoding.
REQ-007 TDI  input  1  serial data in.
REQ-008 TDO  output  1  serial data out, registered.
REQ-009 TDO_EN  output  1  high while TDO carries valid shift data.
REQ-010 USER_IN  input  USER_WIDTH  parallel value captured into user DR.
REQ-011 USER_OUT  output  USER_WIDTH  parallel value latched from user DR on Update-DR.
REQ-012 USER_UPD  output  1  one-cycle pulse when USER_OUT is written.
REQ-013 IR_OUT  output  IR_WIDTH  currently active instruction.

Function
REQ-014 Opcodes: BYPASS = all ones, IDCODE = 4'b0001, USER = 4'b1000 (zero-extended for wider IR); all others SHALL behave as BYPASS.
REQ-015 IR shift register: Capture-IR loads 'b...01 (LSBs 01, remaining bits 0); Shift-IR shifts right, TDI into MSB; Update-IR copies it to IR_OUT.
REQ-016 STATE = Test-Logic-Reset SHALL load IR_OUT with the reset instruction (IDCODE, or BYPASS without IDCODE_EN) on the next edge, regardless of shift contents.
REQ-017 DR selected by IR_OUT: BYPASS 1 bit, IDCODE 32 bits, USER USER_WIDTH bits.
REQ-018 Capture-DR: BYPASS loads 0; IDCODE loads IDCODE_VALUE; USER loads USER_IN.
REQ-019 Shift-DR: selected DR shifts right, TDI into MSB; unselected DRs hold.
REQ-020 Update-DR with USER selected: USER_OUT <= user shift register, USER_UPD = 1 for exactly that cycle; no update for other instructions.
REQ-021 TDO register <= LSB of IR shift register (Shift-IR) or selected DR (Shift-DR), sampled on the same edge as the shift, i.e. one cycle latency from state entry; TDO_EN <= 1 in those states, else 0 and TDO <= 0.
REQ-022 Pause/Exit states SHALL hold all shift registers unchanged.
REQ-023 IR_OUT changes only on Update-IR or Test-Logic-Reset; an instruction change mid-DR-scan is impossible by construction and needs no handling.
REQ-024 Unknown STATE encodings SHALL hold all registers.

Reset
REQ-025 TRST high: IR_OUT = reset instruction, IR/DR shift registers = 0, USER_OUT = 0, USER_UPD = 0, TDO = 0, TDO_EN = 0.
REQ-026 TRST SHALL override STATE on the same edge, including mid-shift; the next scan restarts cleanly from capture.

Configuration
REQ-027 Macro JTAG_IDCODE_EN defined: IDCODE register, opcode and reset instruction IDCODE present.
REQ-028 Macro JTAG_IDCODE_EN undefined: no 32-bit register synthesized, IDCODE opcode decodes as BYPASS, reset instruction BYPASS.

Structure
REQ-029 Shared package jtag_pkg SHALL hold the TAP state typedef/encoding (shared with tar_controller) and opcode constants.
REQ-030 One sub-module, jtag_shift_reg (parameterized width, capture/shift/hold, TDI in, LSB out), instantiated for IR, IDCODE and USER registers; bypass stays inline.

Verification
REQ-031 TRST pulse, then Shift-DR 32 cycles with TDI = 0 -> TDO sequence = 32'h1234_5001 LSB first (with JTAG_IDCODE_EN).
REQ-032 Load IR = 4'b1111, Shift-DR with TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-bit delay through bypass).
REQ-033 Shift-IR 4 cycles -> TDO shows 1,0,0,0 (captured 01 pattern).
REQ-034 IR = USER, USER_IN = 8'hA5, shift in 8'h3C -> TDO = 8'hA5 LSB first; Update-DR -> USER_OUT = 8'h3C, USER_UPD high one cycle.
REQ-035 TRST asserted at USER shift bit 3 -> all outputs at reset values next edge, IR_OUT = 4'b0001; JTAG_IDCODE_EN undefined build -> IR_OUT = 4'b1111.
REQ-036 Pause-DR held 5 cycles mid-shift -> shifted value unchanged on resume, TDO_EN low during pause.
